tone_synth: RTL and testbench



---
 rtl/sound_pkg.sv | 28 ++
 rtl/tone_divider.sv | 39 +++
 rtl/tone_synth.sv | 83 ++++++++
 tb/tb_tone_synth.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: note keys, envelope states and the equal-temperament pitch table.
package sound_pkg;
  localparam logic [3:0] DO = 4'd0, RE = 4'd2, MI = 4'd4, FA = 4'd5, SOL = 4'd7, LA = 4'd9, SI = 4'd11;
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;
  // Half period in clk cycles, round(clk_hz / (2*f)), with f held in millihertz.
  function automatic logic [16:0] half_period(input logic [3:0] key, input longint clk_hz);
    longint f_mhz;
    case (key)
      4'd0:  f_mhz = 261626;
      4'd1:  f_mhz = 277183;
      4'd2:  f_mhz = 293665;
      4'd3:  f_mhz = 311127;
      4'd4:  f_mhz = 329628;
      4'd5:  f_mhz = 349228;
      4'd6:  f_mhz = 369994;
      4'd7:  f_mhz = 391995;
      4'd8:  f_mhz = 415305;
      4'd9:  f_mhz = 440000;
      4'd10: f_mhz = 466164;
      4'd11: f_mhz = 493883;
      4'd12: f_mhz = 523251;
      4'd13: f_mhz = 554365;
      4'd14: f_mhz = 587330;
      default: f_mhz = 622254;
    endcase
    return 17'((clk_hz * 1000 + f_mhz) / (2 * f_mhz));
  endfunction
endpackage

// File: rtl/tone_divider.sv
// tone_divider: square-wave pitch divider; period changes only at wave edges.
module tone_divider
  import sound_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       run,
  input  logic       restart,
  input  logic [3:0] key_lat,
  output logic       wave
);
  localparam logic [16:0] HP0 = half_period(4'd0, longint'(CLK_HZ));
  logic [16:0] tbl [16];
  logic [16:0] div_cnt_q, div_cnt_d, half_per_q, half_per_d;
  logic        wave_q, wave_d, edge_w;
  for (genvar k = 0; k < 16; k++) begin : g_tbl
    assign tbl[k] = half_period(4'(k), longint'(CLK_HZ));
  end
  always_comb begin
    edge_w     = run && div_cnt_q == half_per_q - 17'd1;
    div_cnt_d  = restart || edge_w ? '0 : run ? div_cnt_q + 17'd1 : div_cnt_q;
    wave_d     = restart ? 1'b1 : edge_w ? ~wave_q : wave_q;
    half_per_d = restart || edge_w ? tbl[key_lat] : half_per_q;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt_q  <= '0;
      wave_q     <= 1'b1;
      half_per_q <= HP0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      wave_q     <= wave_d;
      half_per_q <= half_per_d;
    end
  end
  assign wave = wave_q;
endmodule

// File: rtl/tone_synth.sv
// tone_synth: square-wave tone generator with linear attack/release envelope
// producing signed PCM samples on each codec sample tick.
module tone_synth
  import sound_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int AMP_MAX      = 8191,
  parameter int ATTACK_STEP  = 256,
  parameter int RELEASE_STEP = 128
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [3:0]  tone_key,
  input  logic        sound_enable,
  input  logic        sample_tick,
  output logic [15:0] audio_sample,
  output logic        sample_valid,
  output logic        tone_active
);
  localparam logic [15:0] AMAX = 16'(AMP_MAX);
  localparam logic [15:0] AST  = 16'(ATTACK_STEP);
  localparam logic [15:0] RST  = 16'(RELEASE_STEP);
  env_state_t  state_q, state_d;
  logic [15:0] amp_q, amp_d, sum_w, sat_add, sat_sub, sample_q, sample_d;
  logic [3:0]  key_q, key_d;
  logic        valid_q, restart, wave;
  assign restart = state_q == IDLE && sound_enable;
  tone_divider #(.CLK_HZ(CLK_HZ)) u_div (
    .clk    (clk),
    .resetN (resetN),
    .run    (state_q != IDLE),
    .restart(restart),
    .key_lat(restart ? tone_key : key_q),
    .wave   (wave)
  );
  always_comb begin
    sum_w    = amp_q + AST;
    sat_add  = sum_w > AMAX ? AMAX : sum_w;
    sat_sub  = amp_q > RST ? amp_q - RST : '0;
    state_d  = state_q;
    amp_d    = amp_q;
    key_d    = sound_enable ? tone_key : key_q;
    sample_d = sample_tick ? (wave ? amp_q : -amp_q) : sample_q;
    // Enable changes win over a same-cycle tick step in both directions.
    case (state_q)
      IDLE:    state_d = sound_enable ? ATTACK : IDLE;
      ATTACK:
        if (!sound_enable) state_d = RELEASE;
        else if (sample_tick) begin
          amp_d   = sat_add;
          state_d = sat_add == AMAX ? SUSTAIN : ATTACK;
        end
      SUSTAIN: begin
        amp_d   = AMAX;
        state_d = sound_enable ? SUSTAIN : RELEASE;
      end
      default:
        if (sound_enable) state_d = ATTACK;
        else if (sample_tick) begin
          amp_d   = sat_sub;
          state_d = sat_sub == '0 ? IDLE : RELEASE;
        end
    endcase
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      amp_q    <= '0;
      key_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      key_q    <= key_d;
      sample_q <= sample_d;
      valid_q  <= sample_tick;
    end
  end
  assign audio_sample = sample_q;
  assign sample_valid = valid_q;
  assign tone_active  = state_q != IDLE;
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed checks of pitch table, envelope, glitch-free key changes and reset.
module tb_tone_synth;
  import sound_pkg::*;
  typedef struct {logic [3:0] key; int hz; int exp;} vec_t;
  logic        clk = 0, resetN = 0, sound_enable = 0, sample_tick = 0;
  logic [3:0]  tone_key = 0;
  logic [15:0] audio_sample;
  logic        sample_valid, tone_active;
  int          total = 0, bad = 0, minmag = 0, maxmag = 0, len = 0;
  vec_t        vecs [10];

  tone_synth #(.CLK_HZ(500_000)) dut (
    .clk(clk), .resetN(resetN), .tone_key(tone_key), .sound_enable(sound_enable),
    .sample_tick(sample_tick), .audio_sample(audio_sample), .sample_valid(sample_valid),
    .tone_active(tone_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mag();
    int s;
    s = int'($signed(audio_sample));
    return s < 0 ? -s : s;
  endfunction

  task automatic tick_check(input string name, input int exp);
    @(negedge clk) sample_tick = 1;
    @(negedge clk) sample_tick = 0;
    chk({name, " valid"}, int'(sample_valid), 1);
    chk(name, mag(), exp);
  endtask

  // Count negedges until the sample sign flips; optionally drop enable for one clk
  // (then present nk) or just change the key at cycle `at`.
  task automatic wait_edge(input int at, input bit gap, input logic [3:0] nk, output int n_out);
    logic s0;
    s0 = audio_sample[15];
    n_out = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == at) begin
        if (gap) sound_enable = 0;
        else tone_key = nk;
      end
      if (gap && n == at + 1) begin
        sound_enable = 1;
        tone_key = nk;
      end
      if (mag() < minmag) minmag = mag();
      if (mag() > maxmag) maxmag = mag();
      if (audio_sample[15] != s0) begin
        n_out = n;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{4'd9,  50_000_000, 56818}, '{4'd0, 50_000_000, 95556}, '{4'd4, 50_000_000, 75843},
      '{4'd7,  50_000_000, 63776}, '{4'd12, 50_000_000, 47778},
      '{4'd9,  500_000, 568}, '{4'd0, 500_000, 956}, '{4'd4, 500_000, 758},
      '{4'd7,  500_000, 638}, '{4'd12, 500_000, 478}
    };
    foreach (vecs[i])
      chk($sformatf("table key%0d @%0d", vecs[i].key, vecs[i].hz),
          int'(half_period(vecs[i].key, longint'(vecs[i].hz))), vecs[i].exp);

    #12;
    chk("reset sample", int'(audio_sample), 0);
    chk("reset valid", int'(sample_valid), 0);
    chk("reset active", int'(tone_active), 0);
    @(negedge clk) resetN = 1;
    tone_key = LA;
    @(negedge clk);
    chk("active before enable", int'(tone_active), 0);
    sound_enable = 1;
    @(negedge clk);
    chk("active after enable", int'(tone_active), 1);

    for (int j = 1; j <= 34; j++)
      tick_check($sformatf("attack tick %0d", j), (256 * (j - 1) > 8191) ? 8191 : 256 * (j - 1));
    @(negedge clk);
    chk("valid one cycle", int'(sample_valid), 0);

    sound_enable = 0;
    for (int j = 1; j <= 64; j++) begin
      tick_check($sformatf("release tick %0d", j), 8191 - 128 * (j - 1));
      chk($sformatf("release active %0d", j), int'(tone_active), j < 64 ? 1 : 0);
    end
    tick_check("idle sample 1", 0);
    tick_check("idle sample 2", 0);

    @(negedge clk);
    tone_key = LA;
    sound_enable = 1;
    sample_tick = 1;
    repeat (40) @(negedge clk);
    minmag = 99999;
    maxmag = 0;
    wait_edge(0, 0, DO, len);
    wait_edge(0, 0, DO, len);
    chk("A4 half period", len, 568);
    wait_edge(100, 0, DO, len);
    chk("key change old length", len, 568);
    wait_edge(0, 0, DO, len);
    chk("DO half period", len, 956);
    wait_edge(200, 1, MI, len);
    chk("gap DO->MI old length", len, 956);
    wait_edge(0, 0, MI, len);
    chk("MI half period", len, 758);
    wait_edge(200, 1, SOL, len);
    chk("gap MI->SOL old length", len, 758);
    wait_edge(0, 0, SOL, len);
    chk("SOL half period", len, 638);
    chk("gap dip within 128", int'(minmag >= 8063), 1);
    chk("peak amplitude", maxmag, 8191);

    sound_enable = 0;
    repeat (70) @(negedge clk);
    chk("release to idle active", int'(tone_active), 0);
    chk("release to idle sample", int'(audio_sample), 0);
    chk("idle valid pulsing", int'(sample_valid), 1);
    sample_tick = 0;

    @(negedge clk) sound_enable = 1;
    for (int j = 1; j <= 5; j++) tick_check($sformatf("pre-reset tick %0d", j), 256 * (j - 1));
    @(negedge clk);
    tick_check("pre-reset nonzero", 1280);
    #2 resetN = 0;
    #1;
    chk("async reset sample", int'(audio_sample), 0);
    chk("async reset valid", int'(sample_valid), 0);
    chk("async reset active", int'(tone_active), 0);
    @(negedge clk);
    resetN = 1;
    sound_enable = 0;
    tick_check("post reset sample", 0);
    chk("post reset active", int'(tone_active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
